// File: rtl/mpp_pkg.sv
// Shared definitions for the mpp core and its program-memory responder.
package mpp_pkg;

    localparam int unsigned MPP_ADDR_W = 16;
    localparam int unsigned MPP_DATA_W = 8;

    localparam logic [MPP_DATA_W-1:0] MPP_OP_NOP = 8'h00;

    // Bit of the core's out_signals that drives the (inverted) program chip-select.
    localparam int unsigned MPP_SIG_PROG_CS = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRIVE
    } mpp_state_e;

    function automatic logic addr_in_range(input logic [MPP_ADDR_W-1:0] addr,
                                           input int unsigned depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/mpp_prog_mem_if.sv
// Instruction-fetch and load-port signals between the mpp core side and program memory.
interface mpp_prog_mem_if
    import mpp_pkg::*;
#(
    parameter int unsigned ADDR_W = MPP_ADDR_W,
    parameter int unsigned DATA_W = MPP_DATA_W
) ();

    logic              prog_cs_n;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] instruction;
    logic              instr_valid;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              addr_err;

    modport master (
        output prog_cs_n, prog_addr, load_we, load_addr, load_data,
        input  instruction, instr_valid, load_ready, addr_err
    );

    modport slave (
        input  prog_cs_n, prog_addr, load_we, load_addr, load_data,
        output instruction, instr_valid, load_ready, addr_err
    );

endinterface

// File: rtl/mpp_prog_ram.sv
// Single-port synchronous RAM with a registered read that holds until the next read.
module mpp_prog_ram #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AddrW  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AddrW-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mpp_prog_mem.sv
// Wait-stated program memory answering one opcode byte per chip-select assertion from the core,
// with a side-band load port that may write only while no fetch is in flight.
module mpp_prog_mem
    import mpp_pkg::*;
#(
    parameter int unsigned ADDR_W      = MPP_ADDR_W,
    parameter int unsigned DATA_W      = MPP_DATA_W,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic           clk,
    input logic           rst_n,
    mpp_prog_mem_if.slave bus
);

    localparam int unsigned RamAw = $clog2(DEPTH);

    mpp_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              cs_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              ready_en_q;

    logic              accept;
    logic              load_ready;
    logic              load_fire;
    logic              load_ok;
    logic              ram_we;
    logic [RamAw-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // Only a high-to-low chip-select transition starts a fetch.
    assign accept     = (state_q == S_IDLE) && cs_q && !bus.prog_cs_n;
    assign load_ready = ready_en_q && (state_q == S_IDLE) && !accept;
    assign load_fire  = bus.load_we && load_ready;
    assign load_ok    = addr_in_range(bus.load_addr, DEPTH);
    assign ram_we     = load_fire && load_ok;
    assign ram_addr   = accept ? bus.prog_addr[RamAw-1:0] : bus.load_addr[RamAw-1:0];

    mpp_prog_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AddrW  (RamAw)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .re_i    (accept),
        .addr_i  (ram_addr),
        .wdata_i (bus.load_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        err_d   = err_q | (load_fire & ~load_ok);

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    addr_d  = bus.prog_addr;
                    cnt_d   = '0;
                    state_d = (WAIT_STATES == 0) ? S_DRIVE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.prog_cs_n) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == 4'(WAIT_STATES)) begin
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DRIVE: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
                if (addr_in_range(addr_q, DEPTH)) begin
                    instr_d = ram_rdata;
                end else begin
                    instr_d = DATA_W'(MPP_OP_NOP);
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cs_q       <= 1'b1;
            addr_q     <= '0;
            instr_q    <= DATA_W'(MPP_OP_NOP);
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cs_q       <= bus.prog_cs_n;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            ready_en_q <= 1'b1;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.load_ready  = load_ready;
    assign bus.addr_err    = err_q;

endmodule

// File: tb/tb_mpp_prog_mem.sv
// Directed bench for mpp_prog_mem with three instances at WAIT_STATES = 0, 1 and 3.
module tb_mpp_prog_mem;

    logic clk;
    logic rst_n;

    // Index 0: WAIT_STATES=0, index 1: WAIT_STATES=1, index 2: WAIT_STATES=3.
    logic        cs_n   [3];
    logic [15:0] addr_a [3];
    logic        lwe    [3];
    logic [15:0] laddr  [3];
    logic [7:0]  ldata  [3];
    logic [7:0]  instr  [3];
    logic        valid  [3];
    logic        ready  [3];
    logic        err    [3];

    int checks = 0;
    int errors = 0;

    mpp_prog_mem_if bus0 ();
    mpp_prog_mem_if bus1 ();
    mpp_prog_mem_if bus3 ();

    mpp_prog_mem #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    mpp_prog_mem #(.WAIT_STATES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mpp_prog_mem #(.WAIT_STATES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign bus0.prog_cs_n = cs_n[0];
    assign bus0.prog_addr = addr_a[0];
    assign bus0.load_we   = lwe[0];
    assign bus0.load_addr = laddr[0];
    assign bus0.load_data = ldata[0];
    assign instr[0]       = bus0.instruction;
    assign valid[0]       = bus0.instr_valid;
    assign ready[0]       = bus0.load_ready;
    assign err[0]         = bus0.addr_err;

    assign bus1.prog_cs_n = cs_n[1];
    assign bus1.prog_addr = addr_a[1];
    assign bus1.load_we   = lwe[1];
    assign bus1.load_addr = laddr[1];
    assign bus1.load_data = ldata[1];
    assign instr[1]       = bus1.instruction;
    assign valid[1]       = bus1.instr_valid;
    assign ready[1]       = bus1.load_ready;
    assign err[1]         = bus1.addr_err;

    assign bus3.prog_cs_n = cs_n[2];
    assign bus3.prog_addr = addr_a[2];
    assign bus3.load_we   = lwe[2];
    assign bus3.load_addr = laddr[2];
    assign bus3.load_data = ldata[2];
    assign instr[2]       = bus3.instruction;
    assign valid[2]       = bus3.instr_valid;
    assign ready[2]       = bus3.load_ready;
    assign err[2]         = bus3.addr_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fetch(input int d, input int ws, input logic [15:0] a,
                         input logic [7:0] exp, input string nm);
        int         lat;
        logic [7:0] got;
        lat = -1;
        got = 8'h00;
        @(negedge clk);
        cs_n[d]   = 1'b0;
        addr_a[d] = a;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (valid[d]) begin
                lat = i;
                got = instr[d];
            end
        end
        checks++;
        if (lat !== 1 + ws) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", nm, lat, 1 + ws);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s_data: got %02h want %02h", nm, got, exp);
        end
        @(negedge clk);
        checks++;
        if (valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_pulse: got %b want 0", nm, valid[d]);
        end
        cs_n[d] = 1'b1;
    endtask

    task automatic load(input int d, input logic [15:0] a, input logic [7:0] v);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        lwe[d]   = 1'b1;
        laddr[d] = a;
        ldata[d] = v;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (ready[d]) ok = 1'b1;
            @(negedge clk);
        end
        lwe[d] = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL load_%0d_%0h: got ready=%b want 1", d, a, ok);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks += 4;
            if (instr[d] !== 8'h00) begin
                errors++;
                $display("FAIL reset_instr_%0d: got %02h want 00", d, instr[d]);
            end
            if (valid[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_valid_%0d: got %b want 0", d, valid[d]);
            end
            if (ready[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready_%0d: got %b want 0", d, ready[d]);
            end
            if (err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_err_%0d: got %b want 0", d, err[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ready[d] !== 1'b1) begin
                errors++;
                $display("FAIL release_ready_%0d: got %b want 1", d, ready[d]);
            end
        end
    endtask

    task automatic test_load;
        logic [15:0] la [6] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0013};
        logic [7:0]  ld [6] = '{8'h07, 8'hC0, 8'h44, 8'hC1, 8'hCB, 8'h00};
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 6; k++) load(d, la[k], ld[k]);
        end
    endtask

    task automatic test_fetch_seq;
        fetch(1, 1, 16'h0000, 8'h07, "seq0");
        fetch(1, 1, 16'h0001, 8'hC0, "seq1");
        fetch(1, 1, 16'h0002, 8'h44, "seq2");
        fetch(1, 1, 16'h0003, 8'hC1, "seq3");
        fetch(1, 1, 16'h0004, 8'hCB, "seq4");
    endtask

    task automatic test_abort;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        cs_n[1]   = 1'b0;
        addr_a[1] = 16'h0002;
        @(negedge clk);
        cs_n[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (valid[1]) seen = 1'b1;
        end
        checks += 2;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_valid: got %b want 0", seen);
        end
        if (instr[1] !== 8'hCB) begin
            errors++;
            $display("FAIL abort_instr_held: got %02h want cb", instr[1]);
        end
        fetch(1, 1, 16'h0003, 8'hC1, "after_abort");
    endtask

    task automatic test_range;
        checks++;
        if (err[1] !== 1'b0) begin
            errors++;
            $display("FAIL range_err_clear: got %b want 0", err[1]);
        end
        fetch(1, 1, 16'h0100, 8'h00, "range_oor");
        checks++;
        if (err[1] !== 1'b1) begin
            errors++;
            $display("FAIL range_err_set: got %b want 1", err[1]);
        end
        fetch(1, 1, 16'h0000, 8'h07, "range_good");
        checks++;
        if (err[1] !== 1'b1) begin
            errors++;
            $display("FAIL range_err_sticky: got %b want 1", err[1]);
        end
    endtask

    task automatic test_collision;
        int         vi;
        int         ri;
        logic [7:0] got;
        vi  = -1;
        ri  = -1;
        got = 8'h00;
        @(negedge clk);
        cs_n[1]   = 1'b0;
        addr_a[1] = 16'h0000;
        lwe[1]    = 1'b1;
        laddr[1]  = 16'h0005;
        ldata[1]  = 8'hAA;
        #1;
        checks++;
        if (ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL coll_ready_blocked: got %b want 0", ready[1]);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ri >= 0) lwe[1] = 1'b0;
            if (valid[1] && vi < 0) begin
                vi  = i;
                got = instr[1];
            end
            #1;
            if (lwe[1] && ready[1] && ri < 0) ri = i;
        end
        lwe[1] = 1'b0;
        @(negedge clk);
        cs_n[1] = 1'b1;
        checks += 3;
        if (got !== 8'h07) begin
            errors++;
            $display("FAIL coll_fetch_data: got %02h want 07", got);
        end
        if (vi !== 3) begin
            errors++;
            $display("FAIL coll_fetch_cycle: got %0d want 3", vi);
        end
        if (ri !== 3) begin
            errors++;
            $display("FAIL coll_load_cycle: got %0d want 3", ri);
        end
        fetch(1, 1, 16'h0005, 8'hAA, "coll_readback");
    endtask

    task automatic test_latency;
        fetch(0, 0, 16'h0001, 8'hC0, "ws0");
        fetch(0, 0, 16'h0002, 8'h44, "ws0_b");
        fetch(2, 3, 16'h0004, 8'hCB, "ws3");
    endtask

    task automatic test_mid_reset(input int d, input int ws);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        cs_n[d]   = 1'b0;
        addr_a[d] = 16'h0001;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (instr[d] !== 8'h00) begin
            errors++;
            $display("FAIL midrst_instr_%0d: got %02h want 00", d, instr[d]);
        end
        if (valid[d] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_valid_%0d: got %b want 0", d, valid[d]);
        end
        if (ready[d] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ready_%0d: got %b want 0", d, ready[d]);
        end
        rst_n   = 1'b1;
        cs_n[d] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (valid[d]) seen = 1'b1;
        end
        checks += 2;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_valid_%0d: got %b want 0", d, seen);
        end
        if (ready[d] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_idle_%0d: got ready=%b want 1", d, ready[d]);
        end
        fetch(d, ws, 16'h0001, 8'hC0, "midrst_readback");
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            cs_n[d]   = 1'b1;
            addr_a[d] = 16'h0000;
            lwe[d]    = 1'b0;
            laddr[d]  = 16'h0000;
            ldata[d]  = 8'h00;
        end
        rst_n = 1'b0;
        test_reset;
        test_load;
        test_fetch_seq;
        test_abort;
        test_range;
        test_collision;
        test_latency;
        test_mid_reset(1, 1);
        test_mid_reset(2, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
